// File: rtl/ovo_svm_sequencer.sv
// ovo_svm_sequencer: runs one shared binary SVM core over every one-vs-one
// class pair, tallies the votes, and returns the argmax class over valid/ack.
// Ports:
//   clk, rst_n      clock and async active-low reset
//   start           request a classification (taken only in IDLE)
//   features_i      sample features, latched on an accepted start
//   all_weights_i   packed per-pair weight slices
//   all_biases_i    packed per-pair biases
//   svm_ready       core frame-done strobe
//   svm_class       core class bit (1 = vote for j, 0 = vote for i)
//   ack             consumer acknowledge of the result
//   svm_weights_o   weights of the current pair
//   svm_bias_o      bias of the current pair
//   svm_inputs_o    latched features
//   busy            high outside IDLE and DONE
//   valid           result valid, held until ack
//   class_id        winning class
// Build option: define OVO_VOTE_DEBUG_EN to expose the vote counters on votes_o.
module ovo_svm_sequencer #(
    parameter int N_classes   = 6,
    parameter int N_features  = 11,
    parameter int weightWidth = 8,
    parameter int biasWidth   = 12,
    parameter int inputWidth  = 4,
    localparam int N_PAIRS    = N_classes * (N_classes - 1) / 2,
    localparam int CW         = $clog2(N_classes)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [inputWidth*N_features-1:0]         features_i,
    input  logic [N_PAIRS*weightWidth*N_features-1:0] all_weights_i,
    input  logic [N_PAIRS*biasWidth-1:0]             all_biases_i,
    input  logic                                     svm_ready,
    input  logic                                     svm_class,
    input  logic                                     ack,
    output logic [weightWidth*N_features-1:0]        svm_weights_o,
    output logic [biasWidth-1:0]                     svm_bias_o,
    output logic [inputWidth*N_features-1:0]         svm_inputs_o,
    output logic                                     busy,
    output logic                                     valid,
    output logic [CW-1:0]                            class_id
`ifdef OVO_VOTE_DEBUG_EN
    ,
    output logic [N_classes*CW-1:0]                  votes_o
`endif
);

    localparam int PW  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int WSL = weightWidth * N_features;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_RUN,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]                  r_pair;
    logic [CW-1:0]                  r_i;
    logic [CW-1:0]                  r_j;
    logic [CW-1:0]                  r_votes [N_classes];
    logic [CW-1:0]                  r_k;
    logic [CW-1:0]                  r_best;
    logic [CW-1:0]                  r_best_cnt;
    logic [CW-1:0]                  r_class_id;
    logic                           r_valid;
    logic [inputWidth*N_features-1:0] r_feat;

    logic w_accept;
    logic w_vote;
    logic w_scan;
    logic w_release;
    logic w_last_pair;
    logic w_k_last;
    logic w_gt;

    assign w_last_pair = (r_pair == PW'(N_PAIRS - 1));
    assign w_k_last    = (r_k == CW'(N_classes - 1));
    // Strictly greater keeps the lowest index on ties.
    assign w_gt        = (r_votes[r_k] > r_best_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_vote    = 1'b0;
        w_scan    = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_ALIGN;
                end
            end
            // The core frame in flight used stale inputs; drop its result.
            S_ALIGN: begin
                if (svm_ready) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (svm_ready) begin
                    w_vote = 1'b1;
                    if (w_last_pair) begin
                        w_next = S_ARGMAX;
                    end
                end
            end
            S_ARGMAX: begin
                w_scan = 1'b1;
                if (w_k_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Pair index and its (i,j) class pair advance together, only on ready,
    // so the core sees the new slice from its first feature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair <= '0;
            r_i    <= '0;
            r_j    <= CW'(1);
        end else if (w_accept || w_release) begin
            r_pair <= '0;
            r_i    <= '0;
            r_j    <= CW'(1);
        end else if (w_vote && !w_last_pair) begin
            r_pair <= r_pair + PW'(1);
            if (r_j == CW'(N_classes - 1)) begin
                r_i <= r_i + CW'(1);
                r_j <= r_i + CW'(2);
            end else begin
                r_j <= r_j + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_classes; k++) begin
                r_votes[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < N_classes; k++) begin
                r_votes[k] <= '0;
            end
        end else if (w_vote) begin
            if (svm_class) begin
                r_votes[r_j] <= r_votes[r_j] + CW'(1);
            end else begin
                r_votes[r_i] <= r_votes[r_i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_best     <= '0;
            r_best_cnt <= '0;
            r_class_id <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_vote && w_last_pair) begin
                r_k        <= '0;
                r_best     <= '0;
                r_best_cnt <= '0;
            end
            if (w_scan) begin
                if (w_gt) begin
                    r_best     <= r_k;
                    r_best_cnt <= r_votes[r_k];
                end
                if (w_k_last) begin
                    r_class_id <= w_gt ? r_k : r_best;
                    r_valid    <= 1'b1;
                end else begin
                    r_k <= r_k + CW'(1);
                end
            end
            if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat <= '0;
        end else if (w_accept) begin
            r_feat <= features_i;
        end
    end

    assign svm_weights_o = all_weights_i[int'(r_pair) * WSL +: WSL];
    assign svm_bias_o    = all_biases_i[int'(r_pair) * biasWidth +: biasWidth];
    assign svm_inputs_o  = r_feat;
    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign valid         = r_valid;
    assign class_id      = r_class_id;

`ifdef OVO_VOTE_DEBUG_EN
    always_comb begin
        votes_o = '0;
        for (int k = 0; k < N_classes; k++) begin
            votes_o[k*CW +: CW] = r_votes[k];
        end
    end
`endif

endmodule

// File: tb/tb_ovo_svm_sequencer.sv
// tb_ovo_svm_sequencer: directed bench for ovo_svm_sequencer with C=3,
// a scripted core (ready every NF+1 cycles) and hand-computed winners.
module tb_ovo_svm_sequencer;

    localparam int C  = 3;
    localparam int NF = 3;
    localparam int WW = 8;
    localparam int BW = 12;
    localparam int IW = 4;
    localparam int NP = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic svm_ready = 1'b0;
    logic svm_class = 1'b0;
    logic [IW*NF-1:0]    features_i = '0;
    logic [NP*WW*NF-1:0] all_w;
    logic [NP*BW-1:0]    all_b;
    logic [WW*NF-1:0]    svm_weights_o;
    logic [BW-1:0]       svm_bias_o;
    logic [IW*NF-1:0]    svm_inputs_o;
    logic                busy;
    logic                valid;
    logic [CW-1:0]       class_id;

    int errors = 0;
    int checks = 0;

    ovo_svm_sequencer #(
        .N_classes(C), .N_features(NF), .weightWidth(WW),
        .biasWidth(BW), .inputWidth(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .features_i(features_i), .all_weights_i(all_w),
        .all_biases_i(all_b), .svm_ready(svm_ready),
        .svm_class(svm_class), .ack(ack),
        .svm_weights_o(svm_weights_o), .svm_bias_o(svm_bias_o),
        .svm_inputs_o(svm_inputs_o), .busy(busy),
        .valid(valid), .class_id(class_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic cls);
        svm_ready = 1'b0;
        repeat (NF) tick();
        svm_ready = 1'b1;
        svm_class = cls;
        tick();
        svm_ready = 1'b0;
        svm_class = 1'b0;
    endtask

    task automatic chk_pair(input string tag, input int p);
        chk({tag, "_w"}, svm_weights_o, all_w[p*WW*NF +: WW*NF]);
        chk({tag, "_b"}, svm_bias_o, all_b[p*BW +: BW]);
    endtask

    task automatic wait_valid(input string tag, input logic [CW-1:0] exp);
        int n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_class"}, class_id, exp);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_ackvalid"}, valid, 1'b0);
        chk({tag, "_ackbusy"}, busy, 1'b0);
    endtask

    task automatic run_seq(input string tag, input logic [IW*NF-1:0] f,
                           input logic b0, input logic b1, input logic b2,
                           input logic [CW-1:0] exp);
        features_i = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_feat"}, svm_inputs_o, f);
        frame(1'b1);
        frame(b0);
        frame(b1);
        frame(b2);
        wait_valid(tag, exp);
        do_ack(tag);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < NF; k++) begin
                all_w[(p*NF+k)*WW +: WW] = 8'(p*16 + k + 1);
            end
            all_b[p*BW +: BW] = 12'(256*(p+1) + p);
        end

        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_class", class_id, 2'd0);
        chk("rst_feat", svm_inputs_o, 12'h000);
        chk_pair("rst_pair0", 0);
        rst_n = 1'b1;
        tick();

        // Scripted run: bits 0,0,1 -> votes {2,0,1} -> class 0.
        features_i = 12'hABC;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_busy", busy, 1'b1);
        chk("s1_feat", svm_inputs_o, 12'hABC);
        features_i = 12'h123;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_align_start", svm_inputs_o, 12'hABC);
        frame(1'b1);
        chk_pair("s1_after_align", 0);
        frame(1'b0);
        chk_pair("s1_pair1", 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_run_start", svm_inputs_o, 12'hABC);
        chk("s1_run_busy", busy, 1'b1);
        frame(1'b0);
        chk_pair("s1_pair2", 2);
        frame(1'b1);
        wait_valid("s1", 2'd0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("s1_hold_valid", valid, 1'b1);
            chk("s1_hold_class", class_id, 2'd0);
        end
        chk("s1_done_busy", busy, 1'b0);
        ack = 1'b1;
        start = 1'b1;
        tick();
        ack = 1'b0;
        start = 1'b0;
        chk("s1_ack_valid", valid, 1'b0);
        chk("s1_ack_busy", busy, 1'b0);
        tick();
        chk("s1_ack_start_ign", busy, 1'b0);
        chk_pair("s1_idle_pair0", 0);

        // Cyclic tie: bits 0,1,0 -> votes {1,1,1} -> class 0.
        run_seq("tie", 12'h456, 1'b0, 1'b1, 1'b0, 2'd0);
        // bits 1,1,1 -> votes {0,1,2} -> class 2.
        run_seq("c2", 12'h789, 1'b1, 1'b1, 1'b1, 2'd2);
        // bits 1,0,0 -> votes {1,2,0} -> class 1.
        run_seq("c1", 12'h321, 1'b1, 1'b0, 1'b0, 2'd1);

        // Reset in RUN at pair 2, then a fresh run.
        features_i = 12'hDEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);
        chk_pair("rr_pair2", 2);
        rst_n = 1'b0;
        #1;
        chk("rr_busy", busy, 1'b0);
        chk("rr_valid", valid, 1'b0);
        chk("rr_feat", svm_inputs_o, 12'h000);
        chk_pair("rr_pair0", 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rr_idle", busy, 1'b0);
        run_seq("rr", 12'h5A5, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
